// File: rtl/bpb_pkg.sv
// Shared types and constants for the branch prediction buffer and its update controller.
package bpb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_SETS   = 16;
   localparam int DEF_WAYS   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PROBE = 2'd1,
      WRITE = 2'd2
   } bpb_state_t;

   localparam logic [1:0] CTR_SNT = 2'd0;
   localparam logic [1:0] CTR_WNT = 2'd1;
   localparam logic [1:0] CTR_WT  = 2'd2;
   localparam logic [1:0] CTR_ST  = 2'd3;

   // Way-index width; a direct-mapped buffer still carries one (constant) bit.
   function automatic int way_bits(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/bpb_way_match.sv
// Tag comparison across all ways of one set: hit flag, one-hot and encoded hit way,
// and the lowest-index invalid way.
module bpb_way_match
   import bpb_pkg::*;
#(
   parameter int WAYS  = DEF_WAYS,
   parameter int TAG_W = 26,
   parameter int WW    = way_bits(WAYS)
) (
   input  logic [WAYS-1:0]       valid,
   input  logic [WAYS*TAG_W-1:0] tags,
   input  logic [TAG_W-1:0]      tag,
   output logic                  hit,
   output logic [WAYS-1:0]       hit_vec,
   output logic [WW-1:0]         hit_way,
   output logic                  any_invalid,
   output logic [WW-1:0]         first_invalid
);

   always_comb begin
      hit_vec       = '0;
      hit_way       = '0;
      first_invalid = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_vec[w] = valid[w] && (tags[w*TAG_W +: TAG_W] == tag);
         if (hit_vec[w]) hit_way = WW'(w);
      end
      // Scan downwards so the lowest invalid index is the one left standing.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w]) first_invalid = WW'(w);
      end
      hit         = |hit_vec;
      any_invalid = ~&valid;
   end

endmodule

// File: rtl/bpb_ctrl.sv
// Set-associative branch prediction buffer with a combinational fetch lookup and a
// three-state IDLE/PROBE/WRITE controller that trains or allocates entries from execute.
module bpb_ctrl
   import bpb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int SETS     = DEF_SETS,
   parameter int WAYS     = DEF_WAYS,
   parameter int ALLOC_NT = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              stall,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [ADDR_W-1:0] res_pc,
   input  logic              res_taken,
   input  logic [ADDR_W-1:0] res_target,
   output logic              busy
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam int WW    = way_bits(WAYS);

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [1:0]        ctr;
      logic [ADDR_W-1:0] target;
   } bpb_entry_t;

   function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic up);
      if (up) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
      else    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
   endfunction

   bpb_entry_t        ent [SETS][WAYS];
   logic [WW-1:0]     ptr [SETS];
   bpb_state_t        state;

   logic [IDX_W-1:0]  idx_p0;
   logic [TAG_W-1:0]  tag_p0;
   logic              taken_p0;
   logic [ADDR_W-1:0] target_p0;
   logic              hit_p1;
   logic [WW-1:0]     hit_way_p1;
   logic              any_inv_p1;
   logic [WW-1:0]     inv_way_p1;

   logic              accept;
   logic [WW-1:0]     victim;

   assign res_ready = ~busy & ~stall;
   assign accept    = res_valid & res_ready;

   // Fetch-side lookup
   logic [IDX_W-1:0]       lk_idx;
   logic [TAG_W-1:0]       lk_tag;
   logic [WAYS-1:0]        lk_valid;
   logic [WAYS*TAG_W-1:0]  lk_tags;
   logic                   lk_hit;
   logic [WAYS-1:0]        lk_hit_vec;
   logic [WW-1:0]          lk_hit_way;
   logic                   lk_any_inv;
   logic [WW-1:0]          lk_first_inv;

   assign lk_idx = lookup_pc[IDX_W+1:2];
   assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];

   always_comb begin
      lk_valid = '0;
      lk_tags  = '0;
      for (int w = 0; w < WAYS; w++) begin
         lk_valid[w]                = ent[lk_idx][w].valid;
         lk_tags[w*TAG_W +: TAG_W]  = ent[lk_idx][w].tag;
      end
   end

   bpb_way_match #(.WAYS(WAYS), .TAG_W(TAG_W), .WW(WW)) u_lookup_match (
      .valid         (lk_valid),
      .tags          (lk_tags),
      .tag           (lk_tag),
      .hit           (lk_hit),
      .hit_vec       (lk_hit_vec),
      .hit_way       (lk_hit_way),
      .any_invalid   (lk_any_inv),
      .first_invalid (lk_first_inv)
   );

   always_comb begin
      pred_taken  = 1'b0;
      pred_target = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (lk_hit_vec[w]) begin
            pred_taken  = ent[lk_idx][w].ctr[1];
            pred_target = ent[lk_idx][w].target;
         end
      end
   end

   assign pred_hit = lk_hit;

   // Update-side probe of the captured set
   logic [WAYS-1:0]        pr_valid;
   logic [WAYS*TAG_W-1:0]  pr_tags;
   logic                   pr_hit;
   logic [WAYS-1:0]        pr_hit_vec;
   logic [WW-1:0]          pr_hit_way;
   logic                   pr_any_inv;
   logic [WW-1:0]          pr_first_inv;

   always_comb begin
      pr_valid = '0;
      pr_tags  = '0;
      for (int w = 0; w < WAYS; w++) begin
         pr_valid[w]               = ent[idx_p0][w].valid;
         pr_tags[w*TAG_W +: TAG_W] = ent[idx_p0][w].tag;
      end
   end

   bpb_way_match #(.WAYS(WAYS), .TAG_W(TAG_W), .WW(WW)) u_probe_match (
      .valid         (pr_valid),
      .tags          (pr_tags),
      .tag           (tag_p0),
      .hit           (pr_hit),
      .hit_vec       (pr_hit_vec),
      .hit_way       (pr_hit_way),
      .any_invalid   (pr_any_inv),
      .first_invalid (pr_first_inv)
   );

   logic lint_unused;
   assign lint_unused = ^{lk_hit_way, lk_any_inv, lk_first_inv, pr_hit_vec,
                          lookup_pc[1:0], res_pc[1:0]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else if (!stall) begin
         case (state)
            IDLE: begin
               if (res_valid) begin
                  state <= PROBE;
                  busy  <= 1'b1;
               end
            end
            PROBE: state <= WRITE;
            WRITE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // p0: resolved branch captured at the handshake
   always_ff @(posedge clk) begin
      if (accept) begin
         idx_p0    <= res_pc[IDX_W+1:2];
         tag_p0    <= res_pc[ADDR_W-1:IDX_W+2];
         taken_p0  <= res_taken;
         target_p0 <= res_target;
      end
   end

   // p1: probe result registered for the WRITE cycle
   always_ff @(posedge clk) begin
      if (!stall && state == PROBE) begin
         hit_p1     <= pr_hit;
         hit_way_p1 <= pr_hit_way;
         any_inv_p1 <= pr_any_inv;
         inv_way_p1 <= pr_first_inv;
      end
   end

   assign victim = any_inv_p1 ? inv_way_p1 : ptr[idx_p0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int s = 0; s < SETS; s++) begin
            ptr[s] <= '0;
            for (int w = 0; w < WAYS; w++) ent[s][w] <= '0;
         end
      end else if (!stall && state == WRITE) begin
         if (hit_p1) begin
            ent[idx_p0][hit_way_p1].ctr <= sat_ctr(ent[idx_p0][hit_way_p1].ctr, taken_p0);
            if (taken_p0) ent[idx_p0][hit_way_p1].target <= target_p0;
         end else if (taken_p0 || (ALLOC_NT != 0)) begin
            ent[idx_p0][victim] <= '{valid:  1'b1,
                                     tag:    tag_p0,
                                     ctr:    taken_p0 ? CTR_WT : CTR_WNT,
                                     target: target_p0};
            // The round-robin pointer only moves when it actually chose the victim.
            if (!any_inv_p1) ptr[idx_p0] <= WW'((int'(victim) + 1) % WAYS);
         end
      end
   end

endmodule

// File: tb/tb_bpb_ctrl.sv
// Bench for bpb_ctrl: two instances (ALLOC_NT=0 and 1) share stimulus and are checked
// against an array-based reference of the buffer contents.
module tb_bpb_ctrl;

   localparam int ADDR_W = 32;
   localparam int SETS   = 16;
   localparam int WAYS   = 2;
   localparam int IDX_W  = 4;

   logic              clk;
   logic              resetn;
   logic              stall;
   logic [ADDR_W-1:0] lookup_pc;
   logic              res_valid;
   logic [ADDR_W-1:0] res_pc;
   logic              res_taken;
   logic [ADDR_W-1:0] res_target;

   logic              hit    [2];
   logic              ptaken [2];
   logic [ADDR_W-1:0] ptgt   [2];
   logic              ready  [2];
   logic              busy   [2];

   int checks   = 0;
   int failures = 0;

   bpb_ctrl #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .ALLOC_NT(0)) u_dut0 (
      .clk(clk), .resetn(resetn), .stall(stall), .lookup_pc(lookup_pc),
      .pred_hit(hit[0]), .pred_taken(ptaken[0]), .pred_target(ptgt[0]),
      .res_valid(res_valid), .res_ready(ready[0]), .res_pc(res_pc),
      .res_taken(res_taken), .res_target(res_target), .busy(busy[0])
   );

   bpb_ctrl #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(WAYS), .ALLOC_NT(1)) u_dut1 (
      .clk(clk), .resetn(resetn), .stall(stall), .lookup_pc(lookup_pc),
      .pred_hit(hit[1]), .pred_taken(ptaken[1]), .pred_target(ptgt[1]),
      .res_valid(res_valid), .res_ready(ready[1]), .res_pc(res_pc),
      .res_taken(res_taken), .res_target(res_target), .busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference contents per instance
   bit          m_valid [2][SETS][WAYS];
   int unsigned m_tag   [2][SETS][WAYS];
   int          m_ctr   [2][SETS][WAYS];
   logic [31:0] m_tgt   [2][SETS][WAYS];
   int          m_ptr   [2][SETS];

   function automatic void m_reset();
      for (int k = 0; k < 2; k++)
         for (int s = 0; s < SETS; s++) begin
            m_ptr[k][s] = 0;
            for (int w = 0; w < WAYS; w++) begin
               m_valid[k][s][w] = 0; m_tag[k][s][w] = 0;
               m_ctr[k][s][w] = 0;   m_tgt[k][s][w] = 0;
            end
         end
   endfunction

   function automatic void m_update(int k, logic [31:0] pc, bit tk, logic [31:0] tg);
      int s, hw, victim;
      int unsigned t;
      s = int'((pc >> 2) % SETS);
      t = pc >> (2 + IDX_W);
      hw = -1;
      victim = -1;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[k][s][w] && m_tag[k][s][w] == t) hw = w;
      if (hw >= 0) begin
         if (tk) begin
            m_ctr[k][s][hw] = (m_ctr[k][s][hw] >= 3) ? 3 : m_ctr[k][s][hw] + 1;
            m_tgt[k][s][hw] = tg;
         end else if (m_ctr[k][s][hw] > 0) begin
            m_ctr[k][s][hw] = m_ctr[k][s][hw] - 1;
         end
      end else if (tk || k == 1) begin
         for (int w = WAYS - 1; w >= 0; w--)
            if (!m_valid[k][s][w]) victim = w;
         if (victim < 0) begin
            victim = m_ptr[k][s];
            m_ptr[k][s] = (m_ptr[k][s] + 1) % WAYS;
         end
         m_valid[k][s][victim] = 1;
         m_tag[k][s][victim]   = t;
         m_ctr[k][s][victim]   = tk ? 2 : 1;
         m_tgt[k][s][victim]   = tg;
      end
   endfunction

   function automatic void m_lookup(int k, logic [31:0] pc, output bit h, output bit tk,
                                    output logic [31:0] tg);
      int s;
      int unsigned t;
      s = int'((pc >> 2) % SETS);
      t = pc >> (2 + IDX_W);
      h = 0; tk = 0; tg = '0;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[k][s][w] && m_tag[k][s][w] == t) begin
            h = 1; tk = (m_ctr[k][s][w] >= 2); tg = m_tgt[k][s][w];
         end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_lookup(input string tag, input logic [31:0] pc);
      bit eh, et;
      logic [31:0] eg;
      lookup_pc = pc;
      #1;
      for (int k = 0; k < 2; k++) begin
         m_lookup(k, pc, eh, et, eg);
         chk($sformatf("%s_d%0d_hit_%0h", tag, k, pc), 32'(hit[k]), 32'(eh));
         chk($sformatf("%s_d%0d_taken_%0h", tag, k, pc), 32'(ptaken[k]), 32'(et));
         chk($sformatf("%s_d%0d_target_%0h", tag, k, pc), ptgt[k], eg);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic exp_busy, input logic exp_ready);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_d%0d_busy", tag, k), 32'(busy[k]), 32'(exp_busy));
         chk($sformatf("%s_d%0d_ready", tag, k), 32'(ready[k]), 32'(exp_ready));
      end
   endtask

   // One full resolution with latency checks at every stage.
   task automatic resolve(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
      @(negedge clk);
      res_pc = pc; res_taken = tk; res_target = tg; res_valid = 1'b1;
      #1 chk_ctl("idle", 1'b0, 1'b1);
      @(posedge clk);
      #1 res_valid = 1'b0;
      @(negedge clk);
      chk_ctl("probe", 1'b1, 1'b0);
      @(negedge clk);
      chk_ctl("write", 1'b1, 1'b0);
      check_lookup("prewrite", pc);
      @(posedge clk);
      m_update(0, pc, tk, tg);
      m_update(1, pc, tk, tg);
      @(negedge clk);
      chk_ctl("done", 1'b0, 1'b1);
      check_lookup("post", pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pc;
      resetn = 1'b0; stall = 1'b0; res_valid = 1'b0;
      res_pc = '0; res_taken = 1'b0; res_target = '0; lookup_pc = 32'h1000;
      m_reset();
      #1;
      chk_ctl("reset", 1'b0, 1'b1);
      check_lookup("reset", 32'h1000);
      chk("reset_hit0_const", 32'(hit[0]), 32'd0);
      chk("reset_tgt0_const", ptgt[0], 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // Allocate, then train down, saturate at 0, train up, saturate at 3
      resolve(32'h1000, 1'b1, 32'h2000);
      chk("alloc_hit_const", 32'(hit[0]), 32'd1);
      chk("alloc_tgt_const", ptgt[0], 32'h2000);
      repeat (3) resolve(32'h1000, 1'b0, 32'h5555);
      chk("sat0_taken_const", 32'(ptaken[0]), 32'd0);
      repeat (4) resolve(32'h1000, 1'b1, 32'h2100);
      chk("sat3_taken_const", 32'(ptaken[0]), 32'd1);
      resolve(32'h1000, 1'b0, 32'h0);
      chk("from3_taken_const", 32'(ptaken[0]), 32'd1);

      // Fill both ways of set 0, then evict way 0 through the pointer
      resolve(32'h1040, 1'b1, 32'h3040);
      resolve(32'h1080, 1'b1, 32'h3080);
      @(negedge clk);
      check_lookup("evict", 32'h1000);
      chk("evict_miss_const", 32'(hit[0]), 32'd0);
      check_lookup("evict", 32'h1040);
      chk("evict_keep_const", 32'(hit[0]), 32'd1);
      check_lookup("evict", 32'h1080);
      resolve(32'h10c0, 1'b1, 32'h30c0);
      check_lookup("evict2", 32'h1080);

      // Not-taken miss allocates only with ALLOC_NT=1
      resolve(32'h3004, 1'b0, 32'h4444);
      chk("nt_d0_hit_const", 32'(hit[0]), 32'd0);
      chk("nt_d1_hit_const", 32'(hit[1]), 32'd1);
      chk("nt_d1_taken_const", 32'(ptaken[1]), 32'd0);

      // Stall in IDLE blocks the handshake, stall in PROBE delays the write 3 cycles
      @(negedge clk);
      res_pc = 32'h5008; res_taken = 1'b1; res_target = 32'h6008; res_valid = 1'b1;
      stall = 1'b1;
      #1 chk_ctl("stall_idle", 1'b0, 1'b0);
      @(negedge clk);
      chk_ctl("stall_idle2", 1'b0, 1'b0);
      stall = 1'b0;
      #1 chk_ctl("unstall_idle", 1'b0, 1'b1);
      @(posedge clk);
      #1 res_valid = 1'b0;
      @(negedge clk);
      stall = 1'b1;
      #1 chk_ctl("stall_probe", 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_ctl($sformatf("stalled%0d", i), 1'b1, 1'b0);
         check_lookup($sformatf("stalled%0d", i), 32'h5008);
      end
      stall = 1'b0;
      @(negedge clk);
      chk_ctl("stall_write", 1'b1, 1'b0);
      check_lookup("stall_prewrite", 32'h5008);
      @(posedge clk);
      m_update(0, 32'h5008, 1'b1, 32'h6008);
      m_update(1, 32'h5008, 1'b1, 32'h6008);
      @(negedge clk);
      chk_ctl("stall_done", 1'b0, 1'b1);
      check_lookup("stall_post", 32'h5008);
      chk("stall_post_hit_const", 32'(hit[0]), 32'd1);

      // Reset pulsed during WRITE discards the in-flight update
      @(negedge clk);
      res_pc = 32'h7010; res_taken = 1'b1; res_target = 32'h8010; res_valid = 1'b1;
      @(posedge clk);
      #1 res_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_ctl("rst_write", 1'b1, 1'b0);
      resetn = 1'b0;
      m_reset();
      #1 chk_ctl("rst_mid", 1'b0, 1'b1);
      check_lookup("rst_mid", 32'h1040);
      chk("rst_mid_hit_const", 32'(hit[0]), 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      chk_ctl("rst_after", 1'b0, 1'b1);
      check_lookup("rst_after", 32'h7010);
      check_lookup("rst_after", 32'h5008);

      // Randomised traffic over a few sets with colliding tags
      for (int n = 0; n < 40; n++) begin
         pc = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 2)
              | 32'($urandom_range(0, 3));
         resolve(pc, ($urandom_range(0, 2) != 0), $urandom);
         @(negedge clk);
         for (int j = 0; j < 3; j++)
            check_lookup("rand", (32'($urandom_range(0, 5)) << 6)
                                 | (32'($urandom_range(0, 3)) << 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
